// File: rtl/timer_pkg.sv
// Shared types and mode encodings for the multi-mode timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_e;

  localparam logic [1:0] MODE_UP_FREE  = 2'd0;
  localparam logic [1:0] MODE_UP_LIMIT = 2'd1;
  localparam logic [1:0] MODE_DOWN     = 2'd2;

  // The reserved encoding behaves as free-running up-count.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_UP_FREE : m;
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: registers the input and flags a low-to-high change.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic en_q;

  always_ff @(posedge clk) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= sig_i;
  end

  assign rise_o = sig_i & ~en_q;

endmodule

// File: rtl/timer_multi_mode.sv
// Programmable-rate timer: prescaler tick drives up-free, up-to-limit or down-count.
module timer_multi_mode
  import timer_pkg::*;
#(
  parameter int CLK_DIV = 5_000_000,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_en,
  input  logic             t_clr,
  input  logic [1:0]       t_mode,
  input  logic [WIDTH-1:0] t_load,
  output logic             t_valid,
  output logic [WIDTH-1:0] t_out,
  output logic             t_done,
  output logic             t_busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [1:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             rise;
  logic             tick;
  logic [1:0]       new_mode;
  logic [WIDTH-1:0] nxt;

  edge_detector u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_i  (t_en),
    .rise_o (rise)
  );

  assign new_mode = norm_mode(t_mode);
  assign tick     = (pre_q == PRE_MAX);
  assign nxt      = (mode_q == MODE_DOWN) ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (t_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (rise) begin
            mode_d = new_mode;
            lim_d  = t_load;
            pre_d  = '0;
            // A zero limit/start value has nothing to count: finish immediately.
            if (new_mode != MODE_UP_FREE && t_load == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = RUN;
              cnt_d   = (new_mode == MODE_DOWN) ? t_load : '0;
            end
          end
        end
        RUN: begin
          if (rise) begin
            state_d = PAUSE;
          end else if (tick) begin
            pre_d   = '0;
            cnt_d   = nxt;
            valid_d = 1'b1;
            if ((mode_q == MODE_UP_LIMIT && nxt == lim_q) ||
                (mode_q == MODE_DOWN && nxt == '0)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        PAUSE: begin
          if (rise) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= '0;
      pre_q   <= '0;
      mode_q  <= MODE_UP_FREE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign t_out   = cnt_q;
  assign t_valid = valid_q;
  assign t_done  = done_q;
  assign t_busy  = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_timer_multi_mode.sv
// Randomised and directed bench for timer_multi_mode at CLK_DIV=4 and CLK_DIV=1.
module tb_timer_multi_mode;

  logic       clk;
  logic       rst;
  logic       t_en;
  logic       t_clr;
  logic [1:0] t_mode;
  logic [7:0] t_load;

  logic       vld4, dn4, bsy4, vld1, dn1, bsy1;
  logic [7:0] out4, out1;

  timer_multi_mode #(.CLK_DIV(4), .WIDTH(8)) u_d4 (
    .clk(clk), .rst(rst), .t_en(t_en), .t_clr(t_clr), .t_mode(t_mode), .t_load(t_load),
    .t_valid(vld4), .t_out(out4), .t_done(dn4), .t_busy(bsy4)
  );

  timer_multi_mode #(.CLK_DIV(1), .WIDTH(8)) u_d1 (
    .clk(clk), .rst(rst), .t_en(t_en), .t_clr(t_clr), .t_mode(t_mode), .t_load(t_load),
    .t_valid(vld1), .t_out(out1), .t_done(dn1), .t_busy(bsy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: counts RUN cycles and ticks, derives the output arithmetically.
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  int DIV [2] = '{4, 1};
  int st [2], runc [2], ticks [2], md [2], ld [2], e_out [2];
  bit e_vld [2], e_dn [2];
  bit prev_en;
  int nv4, nd4, nv1, nd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise;
    rise = t_en && !prev_en;
    for (int i = 0; i < 2; i++) begin
      e_vld[i] = 0;
      e_dn[i]  = 0;
      if (rst || t_clr) begin
        st[i]    = S_IDLE;
        e_out[i] = 0;
      end else begin
        case (st[i])
          S_IDLE, S_DONE: if (rise) begin
            md[i]    = (t_mode == 2'd3) ? 0 : int'(t_mode);
            ld[i]    = int'(t_load);
            runc[i]  = 0;
            ticks[i] = 0;
            if (md[i] != 0 && ld[i] == 0) begin
              st[i] = S_DONE; e_dn[i] = 1; e_out[i] = 0;
            end else begin
              st[i] = S_RUN; e_out[i] = (md[i] == 2) ? ld[i] : 0;
            end
          end
          S_RUN: if (rise) st[i] = S_PAUSE;
          else begin
            runc[i]++;
            if (runc[i] % DIV[i] == 0) begin
              ticks[i]++;
              e_vld[i] = 1;
              case (md[i])
                0:       e_out[i] = ticks[i] % 256;
                1:       e_out[i] = ticks[i];
                default: e_out[i] = ld[i] - ticks[i];
              endcase
              if (md[i] != 0 && ticks[i] == ld[i]) begin
                st[i] = S_DONE; e_dn[i] = 1;
              end
            end
          end
          S_PAUSE: if (rise) st[i] = S_RUN;
          default: st[i] = S_IDLE;
        endcase
      end
    end
    prev_en = rst ? 1'b0 : t_en;
  endtask

  // One clock: advance the model, let the edge happen, compare on the falling edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("d4 t_out",   32'(out4), 32'(e_out[0]));
    chk("d4 t_valid", 32'(vld4), 32'(e_vld[0]));
    chk("d4 t_done",  32'(dn4),  32'(e_dn[0]));
    chk("d4 t_busy",  32'(bsy4), 32'(st[0] == S_RUN || st[0] == S_PAUSE));
    chk("d1 t_out",   32'(out1), 32'(e_out[1]));
    chk("d1 t_valid", 32'(vld1), 32'(e_vld[1]));
    chk("d1 t_done",  32'(dn1),  32'(e_dn[1]));
    chk("d1 t_busy",  32'(bsy1), 32'(st[1] == S_RUN || st[1] == S_PAUSE));
    if (vld4) nv4++;
    if (dn4)  nd4++;
    if (vld1) nv1++;
    if (dn1)  nd1++;
  endtask

  task automatic pulse_en();
    t_en = 1'b1;
    cyc();
    t_en = 1'b0;
  endtask

  task automatic clear();
    t_clr = 1'b1;
    cyc();
    t_clr = 1'b0;
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 2; i++) begin
      st[i] = S_IDLE; runc[i] = 0; ticks[i] = 0; md[i] = 0; ld[i] = 0; e_out[i] = 0;
    end
    prev_en = 0;
    rst = 1'b1; t_en = 1'b0; t_clr = 1'b0; t_mode = 2'd0; t_load = 8'd0;
    @(negedge clk);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("reset t_out", 32'(out4), 32'd0);
    chk("reset t_busy", 32'(bsy4), 32'd0);

    // Free-running up-count across the 255 -> 0 wrap.
    t_mode = 2'd0; t_load = 8'd77;
    pulse_en();
    nv4 = 0; nd4 = 0; nv1 = 0; nd1 = 0;
    repeat (1030) cyc();
    chk("m0 d4 valid count", 32'(nv4), 32'd257);
    chk("m0 d4 done count", 32'(nd4), 32'd0);
    chk("m0 d1 valid count", 32'(nv1), 32'd1030);
    chk("m0 d1 done count", 32'(nd1), 32'd0);

    // Down-count from 3.
    clear();
    t_mode = 2'd2; t_load = 8'd3;
    pulse_en();
    chk("m2 start t_out", 32'(out4), 32'd3);
    budget = 0;
    while (!dn4 && budget < 20) begin
      cyc();
      budget++;
    end
    chk("m2 done reached", 32'(dn4), 32'd1);
    chk("m2 done latency", 32'(budget), 32'd12);
    chk("m2 final t_out", 32'(out4), 32'd0);
    chk("m2 final valid", 32'(vld4), 32'd1);
    chk("m2 final busy", 32'(bsy4), 32'd0);

    // Up-to-limit with pause/resume mid-prescale.
    clear();
    t_mode = 2'd1; t_load = 8'd5;
    pulse_en();
    repeat (10) cyc();
    chk("m1 pre-pause t_out", 32'(out4), 32'd2);
    pulse_en();
    nv4 = 0;
    repeat (19) cyc();
    chk("m1 pause valids", 32'(nv4), 32'd0);
    chk("m1 pause busy", 32'(bsy4), 32'd1);
    pulse_en();
    cyc();
    chk("m1 resume +1 valid", 32'(vld4), 32'd0);
    cyc();
    chk("m1 resume +2 valid", 32'(vld4), 32'd1);
    chk("m1 resume +2 t_out", 32'(out4), 32'd3);
    budget = 0;
    while (!dn4 && budget < 20) begin
      cyc();
      budget++;
    end
    chk("m1 done t_out", 32'(out4), 32'd5);
    chk("m1 done reached", 32'(dn4), 32'd1);

    // Clear beats a simultaneous start edge; reset mid-run.
    clear();
    t_mode = 2'd0;
    pulse_en();
    repeat (6) cyc();
    t_clr = 1'b1; t_en = 1'b1;
    cyc();
    t_clr = 1'b0;
    chk("clr t_out", 32'(out4), 32'd0);
    repeat (6) cyc();
    chk("clr no restart", 32'(bsy4), 32'd0);
    t_en = 1'b0;
    cyc();
    pulse_en();
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst t_out", 32'(out4), 32'd0);
    chk("rst t_busy", 32'(bsy4), 32'd0);
    chk("rst t_valid", 32'(vld4), 32'd0);

    // Zero-length down-count.
    t_mode = 2'd2; t_load = 8'd0;
    pulse_en();
    chk("zero t_done", 32'(dn4), 32'd1);
    chk("zero t_valid", 32'(vld4), 32'd0);
    chk("zero t_out", 32'(out4), 32'd0);
    cyc();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) t_en = ~t_en;
      t_clr  = ($urandom_range(0, 99) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      t_mode = 2'($urandom_range(0, 3));
      t_load = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      cyc();
    end
    rst = 1'b0; t_clr = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
